audio_serial_ctrl: RTL

AUDIO_SERIAL_CTRL -- requirements
Module: audio_serial_ctrl

---
 rtl/audio_pkg.sv | 34 +++
 rtl/bit_tick_gen.sv | 42 ++++
 rtl/audio_serial_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
//   Shared definitions for the audio serial controller:
//     - default word length, system clock and bit-strobe frequencies
//     - controller FSM state encoding
//     - round-robin pick helper and counter-width helper
// -----------------------------------------------------------------------------
package audio_pkg;

   localparam int WORD_LENGTH_DFLT      = 16;
   localparam int SYSTEM_FREQUENCY_DFLT = 100_000_000;
   localparam int BIT_FREQUENCY_DFLT    = 1_000_000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DRAIN = 2'd3
   } ser_state_t;

   // Two-way round-robin: returns 1 when requester 1 wins.
   // last_grant is the owner of the previous word; when both are valid the
   // other one wins, when only one is valid it wins outright.
   function automatic logic rr_pick1(input logic v0, input logic v1,
                                     input logic last_grant);
      return v1 && (!v0 || !last_grant);
   endfunction

   // Width of a counter holding 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// -----------------------------------------------------------------------------
// bit_tick_gen
//   Divide-by-DIV strobe generator. While run is high the counter walks
//   0..DIV-1 and wraps; tick is high in the cycle the counter sits at DIV-1.
//   clear (or reset) forces the counter back to 0.
//
//   Ports
//     clock_i  : system clock
//     reset_i  : synchronous active-high reset
//     clear    : restart the count from 0
//     run      : count enable
//     tick     : one-cycle strobe every DIV running cycles
// -----------------------------------------------------------------------------
module bit_tick_gen
   import audio_pkg::*;
#(
   parameter int DIV = 100
) (
   input  logic clock_i,
   input  logic reset_i,
   input  logic clear,
   input  logic run,
   output logic tick
);

   localparam int            TW   = cnt_width(DIV);
   localparam logic [TW-1:0] LAST = TW'(DIV - 1);

   logic [TW-1:0] cnt;

   always_ff @(posedge clock_i) begin
      if (reset_i || clear) begin
         cnt <= '0;
      end else if (run) begin
         cnt <= (cnt == LAST) ? '0 : cnt + TW'(1);
      end
   end

   // With DIV=1 the counter is pinned at 0 == LAST, so tick follows run.
   assign tick = run && (cnt == LAST);

endmodule

// File: rtl/audio_serial_ctrl.sv
// -----------------------------------------------------------------------------
// audio_serial_ctrl
//   Two-requester front end for a bit serializer. A round-robin arbiter
//   accepts one word at a time, latches it onto ser_data_o and then issues
//   WORD_LENGTH bit strobes spaced DIV = SYSTEM_FREQUENCY/BIT_FREQUENCY
//   cycles apart. After the last strobe the serializer must answer with
//   ser_done_i within two cycles; a missing or stray done sets a sticky error.
//
//   Ports
//     clock_i               : system clock
//     reset_i               : synchronous active-high reset
//     req0/1_valid_i        : requester has a word
//     req0/1_data_i         : requester word
//     req0/1_ready_o        : word accepted when valid & ready (IDLE only)
//     ser_data_o            : latched word for the serializer
//     ser_enable_o          : one-cycle bit strobe
//     ser_done_i            : serializer last-bit indication
//     busy_o                : FSM not in IDLE
//     grant_o               : owner of the current word
//     err_o                 : sticky protocol error, cleared by reset only
// -----------------------------------------------------------------------------
module audio_serial_ctrl
   import audio_pkg::*;
#(
   parameter int WORD_LENGTH      = WORD_LENGTH_DFLT,
   parameter int SYSTEM_FREQUENCY = SYSTEM_FREQUENCY_DFLT,
   parameter int BIT_FREQUENCY    = BIT_FREQUENCY_DFLT
) (
   input  logic                   clock_i,
   input  logic                   reset_i,
   input  logic                   req0_valid_i,
   input  logic [WORD_LENGTH-1:0] req0_data_i,
   output logic                   req0_ready_o,
   input  logic                   req1_valid_i,
   input  logic [WORD_LENGTH-1:0] req1_data_i,
   output logic                   req1_ready_o,
   output logic [WORD_LENGTH-1:0] ser_data_o,
   output logic                   ser_enable_o,
   input  logic                   ser_done_i,
   output logic                   busy_o,
   output logic                   grant_o,
   output logic                   err_o
);

   // Integer division; BIT_FREQUENCY must not exceed SYSTEM_FREQUENCY.
   localparam int            DIV      = SYSTEM_FREQUENCY / BIT_FREQUENCY;
   localparam int            BW       = $clog2(WORD_LENGTH + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(WORD_LENGTH - 1);

   ser_state_t    state;
   logic          last_grant;
   logic          drain_wait;   // first DRAIN cycle already spent
   logic [BW-1:0] bit_cnt;
   logic          pick1;
   logic          accept;
   logic          tick;

   // ---------------------------------------------------------------------
   // Arbitration: ready is combinational and only offered in IDLE.
   // ---------------------------------------------------------------------
   assign pick1        = rr_pick1(req0_valid_i, req1_valid_i, last_grant);
   assign req0_ready_o = (state == IDLE) && req0_valid_i && !pick1;
   assign req1_ready_o = (state == IDLE) && pick1;
   assign accept       = (req0_valid_i && req0_ready_o) ||
                         (req1_valid_i && req1_ready_o);

   assign busy_o       = (state != IDLE);

   // Strobe comes straight from the registered tick counter; it is only
   // running in SHIFT, so leaving SHIFT (or reset) silences it next cycle.
   assign ser_enable_o = tick;

   bit_tick_gen #(
      .DIV (DIV)
   ) u_tick (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .clear   (state == LOAD),
      .run     (state == SHIFT),
      .tick    (tick)
   );

   // ---------------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state      <= IDLE;
         ser_data_o <= '0;
         grant_o    <= 1'b0;
         err_o      <= 1'b0;
         last_grant <= 1'b1;   // so requester 0 wins the first contest
         bit_cnt    <= '0;
         drain_wait <= 1'b0;
      end else begin
         // A done outside DRAIN has no effect on sequencing, only flags.
         if (ser_done_i && (state != DRAIN))
            err_o <= 1'b1;

         case (state)
            IDLE: begin
               if (accept) begin
                  ser_data_o <= pick1 ? req1_data_i : req0_data_i;
                  grant_o    <= pick1;
                  last_grant <= pick1;
                  state      <= LOAD;
               end
            end

            LOAD: begin
               bit_cnt    <= '0;
               drain_wait <= 1'b0;
               state      <= SHIFT;
            end

            SHIFT: begin
               if (tick) begin
                  if (bit_cnt == LAST_BIT)
                     state <= DRAIN;
                  else
                     bit_cnt <= bit_cnt + BW'(1);
               end
            end

            DRAIN: begin
               if (ser_done_i) begin
                  state <= IDLE;
               end else if (drain_wait) begin
                  // Second DRAIN cycle with no done: give up and flag it.
                  err_o <= 1'b1;
                  state <= IDLE;
               end else begin
                  drain_wait <= 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
